// File: rtl/word_vector_builder_pkg.sv
// word_vector_builder_pkg: shared SHA-256 types and defaults for the message-schedule blocks.
package word_vector_builder_pkg;
  localparam int SHA_WORD_WIDTH = 32;
  localparam int SHA_NUM_WORDS = 64;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} wvb_state_e;
endpackage

// File: rtl/word_vector_builder_word_placer.sv
// word_placer: combinational placement of one word into its slot, optionally bit-reversed.
module word_placer
  import word_vector_builder_pkg::*;
#(
  parameter int WORD_WIDTH = SHA_WORD_WIDTH,
  parameter int NUM_WORDS = SHA_NUM_WORDS,
  parameter int REVERSE_BITS = 1,
  localparam int VECTOR_LENGTH = WORD_WIDTH * NUM_WORDS,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic [VECTOR_LENGTH-1:0] vector_i,
  input  logic [AW-1:0]            address_i,
  input  logic [WORD_WIDTH-1:0]    data_i,
  output logic [VECTOR_LENGTH-1:0] vector_o
);
  logic [WORD_WIDTH-1:0] word;
  for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
    assign word[i] = (REVERSE_BITS != 0) ? data_i[WORD_WIDTH-1-i] : data_i[i];
  end
  for (genvar s = 0; s < NUM_WORDS; s++) begin : g_slot
    assign vector_o[s*WORD_WIDTH +: WORD_WIDTH] = (address_i == AW'(s)) ? word : vector_i[s*WORD_WIDTH +: WORD_WIDTH];
  end
endmodule

// File: rtl/word_vector_builder.sv
// word_vector_builder: assembles addressed words into one wide vector and flags completion.
module word_vector_builder
  import word_vector_builder_pkg::*;
#(
  parameter int WORD_WIDTH = SHA_WORD_WIDTH,
  parameter int NUM_WORDS = SHA_NUM_WORDS,
  parameter int REVERSE_BITS = 1,
  localparam int VECTOR_LENGTH = WORD_WIDTH * NUM_WORDS,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int CW = $clog2(NUM_WORDS + 1)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [AW-1:0]            wr_address_i,
  input  logic [WORD_WIDTH-1:0]    wr_data_i,
  input  logic                     wr_last_i,
  output logic [VECTOR_LENGTH-1:0] vector_o,
  output logic [NUM_WORDS-1:0]     word_loaded_o,
  output logic [CW-1:0]            loaded_count_o,
  output logic                     vector_complete_o,
  output logic                     overwrite_error_o,
  output logic                     range_error_o
);
  wvb_state_e state_q, state_d;
  logic [VECTOR_LENGTH-1:0] vector_q, vector_d, placed;
  logic [NUM_WORDS-1:0] loaded_q, loaded_d;
  logic [CW-1:0] count_q, count_d;
  logic ready_q, complete_q, ovw_q, ovw_d, rng_q, rng_d;
  logic accept, in_range, fresh;
  assign accept = wr_valid_i & ready_q;
  assign in_range = 32'(wr_address_i) < NUM_WORDS;
  assign fresh = in_range & ~loaded_q[wr_address_i];
  word_placer #(
    .WORD_WIDTH(WORD_WIDTH),
    .NUM_WORDS(NUM_WORDS),
    .REVERSE_BITS(REVERSE_BITS)
  ) u_placer (
    .vector_i(vector_q),
    .address_i(wr_address_i),
    .data_i(wr_data_i),
    .vector_o(placed)
  );
  always_comb begin
    state_d = state_q;
    vector_d = vector_q;
    loaded_d = loaded_q;
    count_d = count_q;
    ovw_d = ovw_q;
    rng_d = rng_q;
    if (!enable_i || state_q == IDLE) begin
      state_d = (enable_i && state_q == IDLE) ? LOAD : IDLE;
      vector_d = '0;
      loaded_d = '0;
      count_d = '0;
      ovw_d = 1'b0;
      rng_d = 1'b0;
    end else if (accept) begin
      vector_d = in_range ? placed : vector_q;
      loaded_d = in_range ? (loaded_q | (NUM_WORDS'(1) << wr_address_i)) : loaded_q;
      count_d = count_q + CW'(fresh);
      ovw_d = ovw_q | (in_range & ~fresh);
      rng_d = rng_q | ~in_range;
      state_d = (wr_last_i || count_d == CW'(NUM_WORDS)) ? DONE : LOAD;
    end
  end
  // ready/complete are registered decodes of the next state so every output comes from a flop
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      vector_q <= '0;
      loaded_q <= '0;
      count_q <= '0;
      ovw_q <= 1'b0;
      rng_q <= 1'b0;
      ready_q <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vector_q <= vector_d;
      loaded_q <= loaded_d;
      count_q <= count_d;
      ovw_q <= ovw_d;
      rng_q <= rng_d;
      ready_q <= state_d == LOAD;
      complete_q <= state_d == DONE;
    end
  end
  assign wr_ready_o = ready_q;
  assign vector_o = vector_q;
  assign word_loaded_o = loaded_q;
  assign loaded_count_o = count_q;
  assign vector_complete_o = complete_q;
  assign overwrite_error_o = ovw_q;
  assign range_error_o = rng_q;
endmodule

// File: tb/tb_word_vector_builder.sv
// tb_word_vector_builder: randomized and directed checks of three builder configurations against a slot-array model.
module tb_word_vector_builder;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, wr_valid = 1'b0, wr_last = 1'b0, en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic rdy0, cmp0, ow0, re0, rdy1, cmp1, ow1, re1, rdy2, cmp2, ow2, re2;
  logic [2047:0] vec0;
  logic [63:0] ld0;
  logic [6:0] cnt0;
  logic [31:0] vec1;
  logic [3:0] ld1;
  logic [2:0] cnt1;
  logic [39:0] vec2;
  logic [4:0] ld2;
  logic [2:0] cnt2;

  word_vector_builder u_def (
    .clock_i(clk), .reset_i(rst), .enable_i(en0), .wr_valid_i(wr_valid), .wr_ready_o(rdy0),
    .wr_address_i(wr_addr), .wr_data_i(wr_data), .wr_last_i(wr_last), .vector_o(vec0),
    .word_loaded_o(ld0), .loaded_count_o(cnt0), .vector_complete_o(cmp0),
    .overwrite_error_o(ow0), .range_error_o(re0));

  word_vector_builder #(.WORD_WIDTH(8), .NUM_WORDS(4), .REVERSE_BITS(0)) u_n4 (
    .clock_i(clk), .reset_i(rst), .enable_i(en1), .wr_valid_i(wr_valid), .wr_ready_o(rdy1),
    .wr_address_i(wr_addr[1:0]), .wr_data_i(wr_data[7:0]), .wr_last_i(wr_last), .vector_o(vec1),
    .word_loaded_o(ld1), .loaded_count_o(cnt1), .vector_complete_o(cmp1),
    .overwrite_error_o(ow1), .range_error_o(re1));

  word_vector_builder #(.WORD_WIDTH(8), .NUM_WORDS(5), .REVERSE_BITS(1)) u_n5 (
    .clock_i(clk), .reset_i(rst), .enable_i(en2), .wr_valid_i(wr_valid), .wr_ready_o(rdy2),
    .wr_address_i(wr_addr[2:0]), .wr_data_i(wr_data[7:0]), .wr_last_i(wr_last), .vector_o(vec2),
    .word_loaded_o(ld2), .loaded_count_o(cnt2), .vector_complete_o(cmp2),
    .overwrite_error_o(ow2), .range_error_o(re2));

  int sel = 0;
  logic [2047:0] obs_vec;
  logic [63:0] obs_mask;
  logic [6:0] obs_cnt;
  logic obs_rdy, obs_cmp, obs_ow, obs_re;
  always_comb begin
    obs_vec = sel == 0 ? vec0 : sel == 1 ? 2048'(vec1) : 2048'(vec2);
    obs_mask = sel == 0 ? ld0 : sel == 1 ? 64'(ld1) : 64'(ld2);
    obs_cnt = sel == 0 ? cnt0 : sel == 1 ? 7'(cnt1) : 7'(cnt2);
    obs_rdy = sel == 0 ? rdy0 : sel == 1 ? rdy1 : rdy2;
    obs_cmp = sel == 0 ? cmp0 : sel == 1 ? cmp1 : cmp2;
    obs_ow = sel == 0 ? ow0 : sel == 1 ? ow1 : ow2;
    obs_re = sel == 0 ? re0 : sel == 1 ? re1 : re2;
  end

  int n_cmp = 0, n_bad = 0;
  int cfg_nw, cfg_ww, cfg_aw;
  bit cfg_rev;
  int m_phase;
  logic [31:0] m_words [64];
  bit m_loaded [64];
  int m_count;
  bit m_ovf, m_rng;

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) begin
      m_words[s] = '0;
      m_loaded[s] = 1'b0;
    end
    m_count = 0;
    m_ovf = 1'b0;
    m_rng = 1'b0;
  endfunction

  function automatic logic [2047:0] exp_vec();
    logic [2047:0] v = '0;
    for (int s = 0; s < cfg_nw; s++)
      for (int i = 0; i < cfg_ww; i++)
        if (m_loaded[s]) v[s*cfg_ww+i] = cfg_rev ? m_words[s][cfg_ww-1-i] : m_words[s][i];
    return v;
  endfunction

  function automatic logic [63:0] exp_mask();
    logic [63:0] m = '0;
    for (int s = 0; s < cfg_nw; s++) m[s] = m_loaded[s];
    return m;
  endfunction

  function automatic int diff_chunk(input logic [2047:0] a, input logic [2047:0] b);
    for (int c = 0; c < 64; c++) if (a[c*32 +: 32] !== b[c*32 +: 32]) return c;
    return 0;
  endfunction

  // model phases: 0 idle, 1 loading, 2 complete
  task automatic cycle(input bit r, input bit en, input bit v, input logic [5:0] a, input logic [31:0] d, input bit l);
    int addr;
    rst = r;
    en0 = en && sel == 0;
    en1 = en && sel == 1;
    en2 = en && sel == 2;
    wr_valid = v;
    wr_addr = a;
    wr_data = d;
    wr_last = l;
    addr = int'(a) % (1 << cfg_aw);
    if (r || !en) begin
      m_clear();
      m_phase = 0;
    end else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1 && v) begin
      if (addr < cfg_nw) begin
        if (m_loaded[addr]) m_ovf = 1'b1;
        else begin
          m_loaded[addr] = 1'b1;
          m_count++;
        end
        m_words[addr] = d;
      end else m_rng = 1'b1;
      if (l || m_count == cfg_nw) m_phase = 2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input int s, input int nw, input int ww, input bit rev, input int aw);
    sel = s;
    cfg_nw = nw;
    cfg_ww = ww;
    cfg_rev = rev;
    cfg_aw = aw;
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    start(0, 64, 32, 1, 6);
    n_cmp++; if (obs_vec !== '0) begin n_bad++; $display("FAIL reset_vector chunk %0d got %h want 0", diff_chunk(obs_vec, '0), obs_vec[diff_chunk(obs_vec, '0)*32 +: 32]); end
    n_cmp++; if (obs_mask !== '0) begin n_bad++; $display("FAIL reset_mask got %h want 0", obs_mask); end
    n_cmp++; if (obs_cnt !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", obs_cnt); end
    n_cmp++; if ({obs_rdy, obs_cmp, obs_ow, obs_re} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {obs_rdy, obs_cmp, obs_ow, obs_re}); end
  endtask

  task automatic test_sha_k();
    logic [2047:0] ev;
    start(0, 64, 32, 1, 6);
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++; if (obs_rdy !== 1'b1) begin n_bad++; $display("FAIL sha_ready got %b want 1", obs_rdy); end
    for (int a = 0; a < 64; a++) begin
      cycle(0, 1, 1, 6'(a), K[a], 0);
      n_cmp++; if (obs_cnt !== 7'(a + 1)) begin n_bad++; $display("FAIL sha_count at %0d got %0d want %0d", a, obs_cnt, a + 1); end
      n_cmp++; if (obs_cmp !== (a == 63)) begin n_bad++; $display("FAIL sha_complete at %0d got %b want %b", a, obs_cmp, a == 63); end
    end
    ev = exp_vec();
    n_cmp++; if (obs_vec[31:0] !== 32'h19F45142) begin n_bad++; $display("FAIL sha_slot0 got %h want 19f45142", obs_vec[31:0]); end
    n_cmp++; if (obs_vec !== ev) begin n_bad++; $display("FAIL sha_vector chunk %0d got %h want %h", diff_chunk(obs_vec, ev), obs_vec[diff_chunk(obs_vec, ev)*32 +: 32], ev[diff_chunk(obs_vec, ev)*32 +: 32]); end
    n_cmp++; if ({obs_ow, obs_re, obs_rdy} !== 3'b0) begin n_bad++; $display("FAIL sha_flags got %b want 000", {obs_ow, obs_re, obs_rdy}); end
    n_cmp++; if (obs_mask !== {64{1'b1}}) begin n_bad++; $display("FAIL sha_mask got %h want all ones", obs_mask); end
  endtask

  task automatic test_done_hold();
    logic [2047:0] ev;
    ev = exp_vec();
    for (int c = 0; c < 5; c++) begin
      cycle(0, 1, 1, 6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
      n_cmp++; if (obs_rdy !== 1'b0 || obs_cmp !== 1'b1) begin n_bad++; $display("FAIL hold_flags cycle %0d got rdy=%b cmp=%b want 0 1", c, obs_rdy, obs_cmp); end
      n_cmp++; if (obs_vec !== ev) begin n_bad++; $display("FAIL hold_vector cycle %0d chunk %0d got %h want %h", c, diff_chunk(obs_vec, ev), obs_vec[diff_chunk(obs_vec, ev)*32 +: 32], ev[diff_chunk(obs_vec, ev)*32 +: 32]); end
    end
  endtask

  task automatic test_placement_n4();
    logic [7:0] dat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [5:0] adr [4] = '{6'd2, 6'd0, 6'd3, 6'd1};
    start(1, 4, 8, 0, 2);
    cycle(0, 1, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) begin
      cycle(0, 1, 1, adr[w], 32'(dat[w]), 0);
      n_cmp++; if (obs_cmp !== (w == 3)) begin n_bad++; $display("FAIL n4_complete write %0d got %b want %b", w, obs_cmp, w == 3); end
    end
    n_cmp++; if (obs_vec[31:0] !== 32'hC3A1D4B2) begin n_bad++; $display("FAIL n4_vector got %h want c3a1d4b2", obs_vec[31:0]); end
    n_cmp++; if (obs_vec !== exp_vec()) begin n_bad++; $display("FAIL n4_model got %h want %h", obs_vec[31:0], exp_vec() & 2048'hFFFF_FFFF); end
  endtask

  task automatic test_overwrite();
    start(1, 4, 8, 0, 2);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 6'd1, 32'h11, 0);
    n_cmp++; if (obs_ow !== 1'b0) begin n_bad++; $display("FAIL ovw_early got %b want 0", obs_ow); end
    cycle(0, 1, 1, 6'd1, 32'h22, 1);
    n_cmp++; if (obs_ow !== 1'b1) begin n_bad++; $display("FAIL ovw_flag got %b want 1", obs_ow); end
    n_cmp++; if (obs_cnt !== 7'd1) begin n_bad++; $display("FAIL ovw_count got %0d want 1", obs_cnt); end
    n_cmp++; if (obs_vec[31:0] !== 32'h0000_2200) begin n_bad++; $display("FAIL ovw_vector got %h want 00002200", obs_vec[31:0]); end
    n_cmp++; if (obs_cmp !== 1'b1) begin n_bad++; $display("FAIL ovw_complete got %b want 1", obs_cmp); end
  endtask

  task automatic test_range();
    start(2, 5, 8, 1, 3);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 6'd6, 32'h5A, 0);
    n_cmp++; if (obs_re !== 1'b1) begin n_bad++; $display("FAIL range_flag got %b want 1", obs_re); end
    n_cmp++; if (obs_vec !== '0 || obs_cnt !== '0) begin n_bad++; $display("FAIL range_state got vec=%h cnt=%0d want 0 0", obs_vec[39:0], obs_cnt); end
    n_cmp++; if (obs_rdy !== 1'b1 || obs_cmp !== 1'b0) begin n_bad++; $display("FAIL range_ready got rdy=%b cmp=%b want 1 0", obs_rdy, obs_cmp); end
    cycle(0, 1, 1, 6'd4, 32'h01, 0);
    n_cmp++; if (obs_vec[39:32] !== 8'h80 || obs_re !== 1'b1) begin n_bad++; $display("FAIL range_sticky got slot4=%h re=%b want 80 1", obs_vec[39:32], obs_re); end
    cycle(0, 1, 1, 6'd7, 32'hFF, 1);
    n_cmp++; if (obs_cmp !== 1'b1 || obs_cnt !== 7'd1 || obs_vec !== exp_vec()) begin n_bad++; $display("FAIL range_last got cmp=%b cnt=%0d vec=%h want 1 1 %h", obs_cmp, obs_cnt, obs_vec[39:0], exp_vec() & 2048'hFF_FFFF_FFFF); end
  endtask

  task automatic test_abort();
    start(0, 64, 32, 1, 6);
    cycle(0, 1, 0, 0, 0, 0);
    for (int w = 0; w < 10; w++) cycle(0, 1, 1, 6'(w * 5), $urandom, 0);
    n_cmp++; if (obs_cnt !== 7'd10) begin n_bad++; $display("FAIL abort_precount got %0d want 10", obs_cnt); end
    cycle(1, 1, 1, 6'd60, $urandom, 1);
    n_cmp++; if (obs_vec !== '0 || obs_mask !== '0 || obs_cnt !== '0) begin n_bad++; $display("FAIL abort_clear got mask=%h cnt=%0d want 0 0", obs_mask, obs_cnt); end
    n_cmp++; if ({obs_rdy, obs_cmp, obs_ow, obs_re} !== 4'b0) begin n_bad++; $display("FAIL abort_flags got %b want 0000", {obs_rdy, obs_cmp, obs_ow, obs_re}); end
    cycle(0, 1, 0, 0, 0, 0);
    n_cmp++; if (obs_rdy !== 1'b1) begin n_bad++; $display("FAIL abort_rearm got %b want 1", obs_rdy); end
    for (int w = 0; w < 3; w++) cycle(0, 1, 1, 6'(w), $urandom, 0);
    cycle(0, 0, 1, 6'd9, $urandom, 1);
    n_cmp++; if (obs_vec !== '0 || obs_cnt !== '0 || obs_rdy !== 1'b0 || obs_cmp !== 1'b0) begin n_bad++; $display("FAIL abort_enable got cnt=%0d rdy=%b cmp=%b want 0 0 0", obs_cnt, obs_rdy, obs_cmp); end
  endtask

  task automatic test_random(input int s, input int nw, input int ww, input bit rev, input int aw);
    logic [2047:0] ev;
    start(s, nw, ww, rev, aw);
    for (int c = 0; c < 250; c++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 15) == 0);
      ev = exp_vec();
      n_cmp++; if (obs_vec !== ev) begin n_bad++; $display("FAIL rand%0d_vector cycle %0d chunk %0d got %h want %h", s, c, diff_chunk(obs_vec, ev), obs_vec[diff_chunk(obs_vec, ev)*32 +: 32], ev[diff_chunk(obs_vec, ev)*32 +: 32]); end
      n_cmp++; if (obs_mask !== exp_mask()) begin n_bad++; $display("FAIL rand%0d_mask cycle %0d got %h want %h", s, c, obs_mask, exp_mask()); end
      n_cmp++; if (obs_cnt !== 7'(m_count)) begin n_bad++; $display("FAIL rand%0d_count cycle %0d got %0d want %0d", s, c, obs_cnt, m_count); end
      n_cmp++; if (obs_rdy !== (m_phase == 1) || obs_cmp !== (m_phase == 2)) begin n_bad++; $display("FAIL rand%0d_phase cycle %0d got rdy=%b cmp=%b want %b %b", s, c, obs_rdy, obs_cmp, m_phase == 1, m_phase == 2); end
      n_cmp++; if (obs_ow !== m_ovf || obs_re !== m_rng) begin n_bad++; $display("FAIL rand%0d_errors cycle %0d got ow=%b re=%b want %b %b", s, c, obs_ow, obs_re, m_ovf, m_rng); end
    end
  endtask

  initial begin
    m_clear();
    m_phase = 0;
    test_reset();
    test_sha_k();
    test_done_hold();
    test_placement_n4();
    test_overwrite();
    test_range();
    test_abort();
    test_random(0, 64, 32, 1, 6);
    test_random(1, 4, 8, 0, 2);
    test_random(2, 5, 8, 1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
